// File: rtl/fpu_mul_seq.sv
`timescale 1ns/1ps
// fpu_mul_seq: sequential floating-point multiplier with configurable
// exponent/fraction widths, IEEE special cases, round-to-nearest-even,
// subnormal results and Z/C/N/V condition codes.
//
// Handshake: start is a level request sampled on a rising clock edge
// while the block is in IDLE or DONE. It is accepted on that edge, which
// also captures fpuIn1/fpuIn2. busy is high from the accepting edge
// until the DONE cycle ends. done is a one-cycle pulse in the cycle that
// fpuOut/condCodes first show the new result. There is no back-pressure:
// the result is simply held until the next result overwrites it.
module fpu_mul_seq #(
    parameter int EXPW  = 5,
    parameter int FRACW = 10
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     start,
    input  logic [EXPW+FRACW:0]      fpuIn1,
    input  logic [EXPW+FRACW:0]      fpuIn2,
    output logic [EXPW+FRACW:0]      fpuOut,
    output logic                     done,
    output logic                     busy,
    output logic [3:0]               condCodes,
    output logic [1:0]               dbgState
);

    localparam int W   = 1 + EXPW + FRACW;
    localparam int SW  = FRACW + 1;          // significand width incl. hidden bit
    localparam int PW  = 2 * SW;             // raw product width
    localparam int EW  = EXPW + 2;           // signed working exponent width
    localparam int LZW = $clog2(PW) + 1;     // holds any shift count 0..PW
    // Normalisation can subtract up to PW from the exponent, so it is done
    // in a wider signed type before being clamped into the subnormal range.
    localparam int XW  = EW + LZW + 1;

    localparam logic [EW-1:0]        BIAS_E = EW'((1 << (EXPW - 1)) - 1);
    localparam logic signed [XW-1:0] ONE_X  = 1;
    localparam logic signed [XW-1:0] PW_X   = PW;
    localparam logic signed [XW-1:0] EMAX_X = (1 << EXPW) - 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        NORM = 2'd2,
        DONE = 2'd3
    } stateT;

    typedef enum logic [1:0] {
        SP_NONE = 2'd0,
        SP_NAN  = 2'd1,
        SP_INF  = 2'd2,
        SP_ZERO = 2'd3
    } specialT;

    stateT                 state;
    logic [FRACW-1:0]      count;
    logic [PW-1:0]         prod;      // {partial sum, remaining multiplier bits}
    logic [SW-1:0]         mcand;
    logic signed [EW-1:0]  expSum;
    logic                  signRes;
    specialT               special;

    assign dbgState = state;

    // ------------------------------------------------------------------
    // Operand decode at capture time
    // ------------------------------------------------------------------
    logic [EXPW-1:0]       exp1, exp2, eff1, eff2;
    logic [FRACW-1:0]      frac1, frac2;
    logic                  hid1, hid2;
    logic                  nan1, nan2, inf1, inf2, zero1, zero2;
    logic signed [EW-1:0]  expIn;
    specialT               specialIn;

    assign exp1  = fpuIn1[W-2:FRACW];
    assign exp2  = fpuIn2[W-2:FRACW];
    assign frac1 = fpuIn1[FRACW-1:0];
    assign frac2 = fpuIn2[FRACW-1:0];
    assign hid1  = |exp1;
    assign hid2  = |exp2;
    // Subnormals share the exponent of the smallest normal.
    assign eff1  = hid1 ? exp1 : EXPW'(1);
    assign eff2  = hid2 ? exp2 : EXPW'(1);
    assign nan1  = (&exp1) & (|frac1);
    assign nan2  = (&exp2) & (|frac2);
    assign inf1  = (&exp1) & ~(|frac1);
    assign inf2  = (&exp2) & ~(|frac2);
    assign zero1 = ~hid1 & ~(|frac1);
    assign zero2 = ~hid2 & ~(|frac2);
    assign expIn = $signed({2'b00, eff1}) + $signed({2'b00, eff2}) - $signed(BIAS_E);

    // Classify the operand pair; the multiply still runs for constant latency.
    always_comb begin
        specialIn = SP_NONE;
        if (nan1 || nan2 || (inf1 && zero2) || (zero1 && inf2)) begin
            specialIn = SP_NAN;
        end else if (inf1 || inf2) begin
            specialIn = SP_INF;
        end else if (zero1 || zero2) begin
            specialIn = SP_ZERO;
        end
    end

    // ------------------------------------------------------------------
    // One shift-add step: add multiplicand if the current multiplier LSB
    // is set, then shift the whole product register right by one.
    // ------------------------------------------------------------------
    logic [SW:0] addTerm;

    // Partial-sum adder for the current multiply step.
    always_comb begin
        addTerm = {1'b0, prod[PW-1:SW]} + (prod[0] ? {1'b0, mcand} : '0);
    end

    // ------------------------------------------------------------------
    // Normalise, denormalise, round, pack
    // ------------------------------------------------------------------
    logic [LZW-1:0]        lzc;
    logic                  lzFound;
    logic signed [XW-1:0]  expWide, lzcX, eN, shiftX, eAdj, eF;
    logic [PW-1:0]         normP, lostMask, subP;
    logic [LZW-1:0]        shAmt;
    logic                  lost, guard, rest, roundUp, inexact, overflow, isZero;
    logic [SW:0]           rounded;
    logic [SW-1:0]         mant;
    logic [EXPW-1:0]       expField;
    logic [W-1:0]          nextOut;
    logic [3:0]            nextCc;

    // Leading-zero count below the product MSB (leading one lands at PW-2).
    always_comb begin
        lzc     = '0;
        lzFound = 1'b0;
        for (int i = PW - 2; i >= 0; i--) begin
            if (!lzFound && prod[i]) begin
                lzc     = LZW'(PW - 2 - i);
                lzFound = 1'b1;
            end
        end
    end

    // Result datapath evaluated during NORM.
    always_comb begin
        expWide = {{(XW-EW){expSum[EW-1]}}, expSum};
        lzcX    = {{(XW-LZW){1'b0}}, lzc};

        // Bring the leading one to bit PW-2 (value in [1,2)).
        if (prod[PW-1]) begin
            normP = {1'b0, prod[PW-1:2], prod[1] | prod[0]};
            eN    = expWide + ONE_X;
        end else begin
            normP = prod << lzc;
            eN    = expWide - lzcX;
        end

        // Underflow: shift into the subnormal range, keeping lost bits sticky.
        shiftX = ONE_X - eN;
        shAmt  = '0;
        if (eN < ONE_X) begin
            if (shiftX > PW_X) begin
                shAmt = LZW'(PW);
            end else begin
                shAmt = shiftX[LZW-1:0];
            end
        end
        lostMask = ~({PW{1'b1}} << shAmt);
        lost     = |(normP & lostMask);
        subP     = (normP >> shAmt) | {{(PW-1){1'b0}}, lost};
        eAdj     = (eN < ONE_X) ? ONE_X : eN;

        // Round to nearest, ties to even. Everything below guard is sticky.
        guard    = subP[FRACW-1];
        rest     = |subP[FRACW-2:0];
        roundUp  = guard & (rest | subP[FRACW]);
        rounded  = subP[PW-1:FRACW] + {{SW{1'b0}}, roundUp};
        inexact  = guard | rest;

        // Carry out of the significand: renormalise. A subnormal that rounds
        // up into the hidden bit needs no shift; the hidden bit alone makes
        // it normal with the exponent already at 1.
        if (rounded[SW]) begin
            mant = rounded[SW:1];
            eF   = eAdj + ONE_X;
        end else begin
            mant = rounded[SW-1:0];
            eF   = eAdj;
        end

        overflow = (eF >= EMAX_X);
        expField = mant[FRACW] ? eF[EXPW-1:0] : '0;
        isZero   = ~(|expField) & ~(|mant[FRACW-1:0]);

        // Pack, with special cases overriding the arithmetic result.
        nextOut = {signRes, expField, mant[FRACW-1:0]};
        nextCc  = {isZero, inexact, signRes, 1'b0};
        case (special)
            SP_NAN: begin
                nextOut = {1'b0, {EXPW{1'b1}}, 1'b1, {(FRACW-1){1'b0}}};
                nextCc  = 4'b0000;
            end
            SP_INF: begin
                nextOut = {signRes, {EXPW{1'b1}}, {FRACW{1'b0}}};
                nextCc  = {2'b00, signRes, 1'b0};
            end
            SP_ZERO: begin
                nextOut = {signRes, {(W-1){1'b0}}};
                nextCc  = {1'b1, 1'b0, signRes, 1'b0};
            end
            default: begin
                if (overflow) begin
                    nextOut = {signRes, {EXPW{1'b1}}, {FRACW{1'b0}}};
                    nextCc  = {1'b0, 1'b1, signRes, 1'b1};
                end
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Control FSM with registered outputs
    // ------------------------------------------------------------------
    // DONE accepts a new start just like IDLE, so a held start yields one
    // result every SW+2 cycles; MUL and NORM ignore start.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            count     <= '0;
            prod      <= '0;
            mcand     <= '0;
            expSum    <= '0;
            signRes   <= 1'b0;
            special   <= SP_NONE;
            fpuOut    <= '0;
            condCodes <= '0;
            done      <= 1'b0;
            busy      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state   <= MUL;
                        busy    <= 1'b1;
                        count   <= FRACW'(SW - 1);
                        prod    <= {{SW{1'b0}}, hid2, frac2};
                        mcand   <= {hid1, frac1};
                        expSum  <= expIn;
                        signRes <= fpuIn1[W-1] ^ fpuIn2[W-1];
                        special <= specialIn;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                MUL: begin
                    prod <= {addTerm, prod[SW-1:1]};
                    if (count == '0) begin
                        state <= NORM;
                    end else begin
                        count <= count - 1'b1;
                    end
                end
                NORM: begin
                    fpuOut    <= nextOut;
                    condCodes <= nextCc;
                    done      <= 1'b1;
                    state     <= DONE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fpu_mul_seq.sv
`timescale 1ns/1ps
// Bench for fpu_mul_seq: an fp16 instance and an fp32 instance share a
// clock and reset. Drivers push {condCodes, fpuOut} plus the start edge
// number into queues; monitors pop and compare on every done pulse.
module tb_fpu_mul_seq;

    localparam int SW16 = 11;
    localparam int SW32 = 24;

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    logic reset;
    int   cyc = 0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // ---------------- DUT signals ----------------
    logic        start16, done16, busy16;
    logic [15:0] a16, b16, out16;
    logic [3:0]  cc16;
    logic [1:0]  st16;

    logic        start32, done32, busy32;
    logic [31:0] a32, b32, out32;
    logic [3:0]  cc32;
    logic [1:0]  st32;

    fpu_mul_seq #(.EXPW(5), .FRACW(10)) dut16 (
        .clock(clock), .reset(reset), .start(start16),
        .fpuIn1(a16), .fpuIn2(b16), .fpuOut(out16),
        .done(done16), .busy(busy16), .condCodes(cc16), .dbgState(st16)
    );

    fpu_mul_seq #(.EXPW(8), .FRACW(23)) dut32 (
        .clock(clock), .reset(reset), .start(start32),
        .fpuIn1(a32), .fpuIn2(b32), .fpuOut(out32),
        .done(done32), .busy(busy32), .condCodes(cc32), .dbgState(st32)
    );

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    logic [19:0] exp_q16[$];
    int          t_q16[$];
    logic [35:0] exp_q32[$];
    int          t_q32[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s", name);
    endtask

    // ---------------- monitors ----------------
    logic        prev_done16 = 1'b0;
    logic        prev_done32 = 1'b0;

    always @(negedge clock) begin
        logic [19:0] e;
        int          t;
        if (done16) begin
            check("done16_single_cycle", prev_done16, 1'b0);
            if (exp_q16.size() == 0) begin
                fail_now("done16_unexpected");
            end else begin
                e = exp_q16.pop_front();
                t = t_q16.pop_front();
                check("out16", out16, e[15:0]);
                check("cc16", cc16, e[19:16]);
                check("latency16", cyc - t, SW16 + 1);
            end
        end
        prev_done16 = done16;
    end

    always @(negedge clock) begin
        logic [35:0] e;
        int          t;
        if (done32) begin
            check("done32_single_cycle", prev_done32, 1'b0);
            if (exp_q32.size() == 0) begin
                fail_now("done32_unexpected");
            end else begin
                e = exp_q32.pop_front();
                t = t_q32.pop_front();
                check("out32", out32, e[31:0]);
                check("cc32", cc32, e[35:32]);
                check("latency32", cyc - t, SW32 + 1);
            end
        end
        prev_done32 = done32;
    end

    // ---------------- drivers ----------------
    task automatic wait_idle16();
        int n = 0;
        @(negedge clock);
        while (busy16 && n < 100) begin
            @(negedge clock);
            n++;
        end
        if (busy16) fail_now("busy16_timeout");
    endtask

    task automatic wait_idle32();
        int n = 0;
        @(negedge clock);
        while (busy32 && n < 100) begin
            @(negedge clock);
            n++;
        end
        if (busy32) fail_now("busy32_timeout");
    endtask

    // Returns at the negedge following the accepting edge.
    task automatic issue16(input logic [15:0] a, input logic [15:0] b, input logic [19:0] e);
        wait_idle16();
        a16     = a;
        b16     = b;
        start16 = 1'b1;
        exp_q16.push_back(e);
        @(posedge clock);
        #1;
        t_q16.push_back(cyc);
        @(negedge clock);
        start16 = 1'b0;
    endtask

    task automatic issue32(input logic [31:0] a, input logic [31:0] b, input logic [35:0] e);
        wait_idle32();
        a32     = a;
        b32     = b;
        start32 = 1'b1;
        exp_q32.push_back(e);
        @(posedge clock);
        #1;
        t_q32.push_back(cyc);
        @(negedge clock);
        start32 = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int bad;
        int t0;
        int n;

        reset   = 1'b0;
        start16 = 1'b0;
        a16     = '0;
        b16     = '0;
        start32 = 1'b0;
        a32     = '0;
        b32     = '0;
        repeat (3) @(negedge clock);

        // Reset values
        check("rst_out16", out16, 16'h0000);
        check("rst_cc16", cc16, 4'h0);
        check("rst_done_busy16", {done16, busy16}, 2'b00);
        check("rst_state16", st16, 2'd0);
        check("rst_out32", out32, 32'h0);
        reset = 1'b1;

        // Exact multiply with busy profile: 1.5 * 2 = 3
        issue16(16'h3E00, 16'h4000, {4'b0000, 16'h4200});
        bad = 0;
        for (int k = 0; k <= SW16 + 1; k++) begin
            if (!busy16) bad++;
            @(negedge clock);
        end
        check("busy16_high_cycles", bad, 0);
        check("busy16_low_after", busy16, 1'b0);
        check("state16_idle_after", st16, 2'd0);

        // Rounding: inexact without round-up, tie up to even, tie down to even
        issue16(16'h3C01, 16'h3C01, {4'b0100, 16'h3C02});
        issue16(16'h3C01, 16'h3E00, {4'b0100, 16'h3E02});
        issue16(16'h3C03, 16'h3E00, {4'b0100, 16'h3E04});
        // Subnormal tie to zero, with and without sign
        issue16(16'h0001, 16'h3800, {4'b1100, 16'h0000});
        issue16(16'h8001, 16'h3800, {4'b1110, 16'h8000});
        // Overflow and special cases
        issue16(16'h7BFF, 16'h7BFF, {4'b0101, 16'h7C00});
        issue16(16'h7C00, 16'h0000, {4'b0000, 16'h7E00});
        issue16(16'hFC00, 16'h4000, {4'b0010, 16'hFC00});
        issue16(16'h7E00, 16'h3C00, {4'b0000, 16'h7E00});

        // Start pulse in MUL cycle 5 must be ignored: 2 * 2 = 4
        issue16(16'h4000, 16'h4000, {4'b0000, 16'h4400});
        repeat (4) @(negedge clock);
        a16     = 16'h3C00;
        b16     = 16'h7BFF;
        start16 = 1'b1;
        @(negedge clock);
        start16 = 1'b0;

        // Operand change after the start edge must not matter: 1.5 * 1.5
        issue16(16'h3E00, 16'h3E00, {4'b0000, 16'h4080});
        repeat (3) @(negedge clock);
        a16 = 16'h7BFF;
        b16 = 16'hFC00;

        // start held high: three results, one every SW+2 cycles: 3 * 2 = 6
        wait_idle16();
        a16     = 16'h4200;
        b16     = 16'h4000;
        start16 = 1'b1;
        for (int k = 0; k < 3; k++) exp_q16.push_back({4'b0000, 16'h4600});
        @(posedge clock);
        #1;
        t0 = cyc;
        for (int k = 0; k < 3; k++) t_q16.push_back(t0 + k * (SW16 + 2));
        repeat (2 * (SW16 + 2)) @(posedge clock);
        @(negedge clock);
        start16 = 1'b0;

        // Reset during MUL cycle 4 aborts with no done pulse
        wait_idle16();
        a16     = 16'h3C00;
        b16     = 16'h4000;
        start16 = 1'b1;
        @(posedge clock);
        @(negedge clock);
        start16 = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        #1;
        check("abort_out16", out16, 16'h0000);
        check("abort_cc16", cc16, 4'h0);
        check("abort_done_busy16", {done16, busy16}, 2'b00);
        check("abort_state16", st16, 2'd0);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        repeat (20) @(negedge clock);
        check("post_abort_idle16", {busy16, st16}, 3'b000);
        issue16(16'h3C00, 16'h3C00, {4'b0000, 16'h3C00});

        // fp32 instance
        issue32(32'h3FC00000, 32'h40000000, {4'b0000, 32'h40400000});
        issue32(32'h00800000, 32'h3F000000, {4'b0000, 32'h00400000});
        issue32(32'h7F7FFFFF, 32'h7F7FFFFF, {4'b0101, 32'h7F800000});
        issue32(32'hFFC12345, 32'h3F800000, {4'b0000, 32'h7FC00000});

        // Drain both scoreboards
        n = 0;
        while ((exp_q16.size() != 0 || exp_q32.size() != 0) && n < 300) begin
            @(negedge clock);
            n++;
        end
        check("drain_pending", exp_q16.size() + exp_q32.size(), 0);
        repeat (5) @(negedge clock);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
